// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: per-channel TMDS word aligner and decoder with lock monitoring.
module tmds_rx_decoder #(
  parameter int LOCK_RUN     = 16,
  parameter int SLIP_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [9:0] i_sym,
  output logic       o_valid,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_token,
  output logic       o_locked,
  output logic [3:0] o_offset
);
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int DW = $clog2(SLIP_TIMEOUT + 1);
  localparam int MW = $clog2(LOSS_TIMEOUT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        r_state;
  logic [9:0]    r_prev, r_a;
  logic          r_a_v;
  logic [RW-1:0] r_run;
  logic [DW-1:0] r_dwell;
  logic [MW-1:0] r_miss;

  logic [19:0]   w_win;
  logic [4:0]    w_idx;
  logic [9:0]    w_aligned;
  logic          w_is_tok, w_lock_hit, w_slip, w_loss, w_locked_n;
  logic [1:0]    w_tok_bits;
  logic [7:0]    w_t, w_d;
  logic [RW-1:0] w_run_n;
  logic [DW-1:0] w_dwell_n;
  logic [MW-1:0] w_miss_n;

  assign w_win     = {i_sym, r_prev};
  assign w_idx     = {1'b0, o_offset};
  assign w_aligned = w_win[w_idx +: 10];

  assign w_is_tok   = r_a == 10'b1101010100 || r_a == 10'b0010101011 ||
                      r_a == 10'b0101010100 || r_a == 10'b1010101011;
  assign w_tok_bits = r_a == 10'b0010101011 ? 2'b01 :
                      r_a == 10'b0101010100 ? 2'b10 :
                      r_a == 10'b1010101011 ? 2'b11 : 2'b00;
  assign w_t = r_a[9] ? ~r_a[7:0] : r_a[7:0];
  assign w_d = {w_t[7:1] ^ w_t[6:0] ^ {7{~r_a[8]}}, w_t[0]};

  // Saturating counter successors; the limits are compared against these
  assign w_run_n   = !w_is_tok ? '0 : r_run == RW'(LOCK_RUN) ? r_run : r_run + 1'b1;
  assign w_dwell_n = r_dwell == DW'(SLIP_TIMEOUT) ? r_dwell : r_dwell + 1'b1;
  assign w_miss_n  = w_is_tok ? '0 : r_miss == MW'(LOSS_TIMEOUT) ? r_miss : r_miss + 1'b1;
  assign w_lock_hit = w_run_n == RW'(LOCK_RUN);
  assign w_slip     = w_dwell_n == DW'(SLIP_TIMEOUT);
  assign w_loss     = w_miss_n == MW'(LOSS_TIMEOUT);
  assign w_locked_n = r_state == LOCKED ? !w_loss : w_lock_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= SEARCH;
      r_prev   <= '0;
      r_a      <= '0;
      r_a_v    <= 1'b0;
      r_run    <= '0;
      r_dwell  <= '0;
      r_miss   <= '0;
      o_valid  <= 1'b0;
      o_de     <= 1'b0;
      o_data   <= '0;
      o_ctrl   <= '0;
      o_token  <= 1'b0;
      o_locked <= 1'b0;
      o_offset <= '0;
    end else begin
      if (i_valid) begin
        r_prev <= i_sym;
        r_a    <= w_aligned;
      end
      r_a_v   <= i_valid;
      o_valid <= r_a_v && w_locked_n;
      if (r_a_v) begin
        o_token  <= w_is_tok;
        o_locked <= w_locked_n;
        r_state  <= w_locked_n ? LOCKED : SEARCH;
        o_de     <= w_locked_n && !w_is_tok;
        if (w_locked_n) begin
          o_data <= w_is_tok ? 8'h00 : w_d;
          if (w_is_tok) o_ctrl <= w_tok_bits;
        end
        if (r_state == SEARCH) begin
          r_miss <= '0;
          if (w_lock_hit || w_slip) begin
            r_run   <= '0;
            r_dwell <= '0;
          end else begin
            r_run   <= w_run_n;
            r_dwell <= w_dwell_n;
          end
          // Lock wins over slip when both land on the same beat
          if (!w_lock_hit && w_slip) o_offset <= o_offset == 4'd9 ? 4'd0 : o_offset + 4'd1;
        end else begin
          r_miss <= w_loss ? '0 : w_miss_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb_tmds_rx_decoder: directed checks of alignment, decode, lock loss, gaps and reset.
module tb_tmds_rx_decoder;
  logic       clk = 1'b0, i_rst = 1'b0, i_valid = 1'b0;
  logic [9:0] i_sym = '0;
  logic       a_valid, a_de, a_token, a_locked, b_valid, b_de, b_token, b_locked;
  logic [7:0] a_data, b_data;
  logic [1:0] a_ctrl, b_ctrl;
  logic [3:0] a_offset, b_offset;
  int         pass_cnt = 0, chk_cnt = 0;
  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] prev_a;

  always #5 clk = ~clk;

  tmds_rx_decoder #(.LOCK_RUN(16), .SLIP_TIMEOUT(64), .LOSS_TIMEOUT(64)) dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_sym(i_sym),
    .o_valid(a_valid), .o_de(a_de), .o_data(a_data), .o_ctrl(a_ctrl),
    .o_token(a_token), .o_locked(a_locked), .o_offset(a_offset));

  tmds_rx_decoder #(.LOCK_RUN(8), .SLIP_TIMEOUT(64), .LOSS_TIMEOUT(64)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_sym(i_sym),
    .o_valid(b_valid), .o_de(b_de), .o_data(b_data), .o_ctrl(b_ctrl),
    .o_token(b_token), .o_locked(b_locked), .o_offset(b_offset));

  task automatic drive(input logic [9:0] s, input logic v);
    @(negedge clk);
    i_valid = v;
    i_sym   = s;
    @(posedge clk);
    #1;
  endtask

  // Emulates a deserializer whose word boundary lags the true one by 3 bits
  task automatic drive_rot3(input logic [9:0] a);
    logic [19:0] c;
    c = {a, prev_a} >> 7;
    prev_a = a;
    drive(c[9:0], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_valid = 1'b0; i_sym = '0;
    @(negedge clk);
    i_rst = 1'b0;
    prev_a = '0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if ({a_valid, a_de, a_data, a_ctrl, a_token, a_locked, a_offset} !== 18'd0)
      $display("FAIL reset_a got %h want 0", {a_valid, a_de, a_data, a_ctrl, a_token, a_locked, a_offset}); else pass_cnt++;
    chk_cnt++; if ({b_valid, b_de, b_data, b_ctrl, b_token, b_locked, b_offset} !== 18'd0)
      $display("FAIL reset_b got %h want 0", {b_valid, b_de, b_data, b_ctrl, b_token, b_locked, b_offset}); else pass_cnt++;
  endtask

  task automatic test_offset0();
    do_reset();
    for (int i = 1; i <= 16; i++) drive(tok[0], 1'b1);
    drive(10'b0100000000, 1'b1);
    chk_cnt++; if (a_locked !== 1'b0) $display("FAIL t1_prelock got %b want 0", a_locked); else pass_cnt++;
    drive(10'b0111111111, 1'b1);
    chk_cnt++; if ({a_locked, a_valid, a_de, a_token, a_ctrl, a_offset} !== {4'b1101, 2'b00, 4'd0})
      $display("FAIL t1_lock got %b want 1101000000", {a_locked, a_valid, a_de, a_token, a_ctrl, a_offset}); else pass_cnt++;
    drive(tok[0], 1'b1);
    chk_cnt++; if ({a_de, a_data} !== {1'b1, 8'h00}) $display("FAIL t1_data0 got de=%b d=%h want de=1 d=00", a_de, a_data); else pass_cnt++;
    drive(tok[0], 1'b1);
    chk_cnt++; if ({a_de, a_data, a_ctrl} !== {1'b1, 8'h01, 2'b00}) $display("FAIL t1_data1 got de=%b d=%h c=%b want de=1 d=01 c=00", a_de, a_data, a_ctrl); else pass_cnt++;
  endtask

  task automatic test_slip();
    do_reset();
    for (int k = 1; k <= 215; k++) begin
      drive_rot3(tok[0]);
      if (k == 32 || k == 96 || k == 160) begin
        chk_cnt++; if ({b_offset, b_locked} !== {4'((k - 32) / 64), 1'b0})
          $display("FAIL t2_offset_at_%0d got off=%0d lk=%b want off=%0d lk=0", k, b_offset, b_locked, (k - 32) / 64); else pass_cnt++;
      end
    end
    chk_cnt++; if ({b_locked, b_offset, b_ctrl, b_de} !== {1'b1, 4'd3, 2'b00, 1'b0})
      $display("FAIL t2_lock got lk=%b off=%0d c=%b de=%b want lk=1 off=3 c=00 de=0", b_locked, b_offset, b_ctrl, b_de); else pass_cnt++;
    drive_rot3(10'b0100000000);
    drive_rot3(10'b0111111111);
    drive_rot3(tok[0]);
    chk_cnt++; if ({b_de, b_data} !== {1'b1, 8'h00}) $display("FAIL t2_data0 got de=%b d=%h want de=1 d=00", b_de, b_data); else pass_cnt++;
    drive_rot3(tok[0]);
    chk_cnt++; if ({b_de, b_data, b_offset} !== {1'b1, 8'h01, 4'd3}) $display("FAIL t2_data1 got de=%b d=%h off=%0d want de=1 d=01 off=3", b_de, b_data, b_offset); else pass_cnt++;
  endtask

  task automatic test_loss();
    do_reset();
    for (int m = 1; m <= 102; m++) begin
      drive((m <= 18 || m >= 85) ? tok[0] : 10'b0111111111, 1'b1);
      if (m == 83) begin
        chk_cnt++; if ({a_locked, a_valid, a_de} !== 3'b111) $display("FAIL t3_still_locked got %b want 111", {a_locked, a_valid, a_de}); else pass_cnt++;
      end
      if (m == 84) begin
        chk_cnt++; if ({a_locked, a_valid, a_de, a_offset} !== 7'd0) $display("FAIL t3_loss got lk=%b v=%b de=%b off=%0d want 0", a_locked, a_valid, a_de, a_offset); else pass_cnt++;
      end
      if (m == 101) begin
        chk_cnt++; if (a_locked !== 1'b0) $display("FAIL t3_early_relock got %b want 0", a_locked); else pass_cnt++;
      end
    end
    chk_cnt++; if ({a_locked, a_valid, a_offset} !== {2'b11, 4'd0}) $display("FAIL t3_relock got lk=%b v=%b off=%0d want 1 1 0", a_locked, a_valid, a_offset); else pass_cnt++;
  endtask

  task automatic test_tokens();
    do_reset();
    for (int i = 0; i < 4; i++) drive(tok[0], 1'b1);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) drive(tok[t], 1'b1);
      chk_cnt++; if ({a_locked, a_valid, a_de, a_token, a_ctrl, a_data} !== {4'b1101, 2'(t), 8'h00})
        $display("FAIL t4_token%0d got lk=%b v=%b de=%b tk=%b c=%b d=%h want 1 1 0 1 %0d 00", t, a_locked, a_valid, a_de, a_token, a_ctrl, a_data, t); else pass_cnt++;
    end
    do_reset();
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < 8; i++) begin
        drive(i < 7 ? tok[0] : 10'b0100000000, 1'b1);
        chk_cnt++; if ({a_locked, a_valid} !== 2'b00) $display("FAIL t4_nolock_%0d_%0d got %b want 00", r, i, {a_locked, a_valid}); else pass_cnt++;
      end
  endtask

  task automatic test_gaps();
    logic [9:0] s;
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      s = i <= 16 ? tok[0] : i == 17 ? 10'b0100000000 : i == 18 ? 10'b0111111111 : tok[0];
      drive(s, 1'b1);
      chk_cnt++; if (a_valid !== 1'b0) $display("FAIL t5_gap_valid_%0d got %b want 0", i, a_valid); else pass_cnt++;
      drive(10'h3FF, 1'b0);
      chk_cnt++; if (a_valid !== (i >= 17)) $display("FAIL t5_pulse_%0d got %b want %b", i, a_valid, i >= 17); else pass_cnt++;
      if (i >= 17) begin
        chk_cnt++; if ({a_de, a_data} !== (i == 17 ? 9'h000 : i == 18 ? 9'h100 : 9'h101))
          $display("FAIL t5_dec_%0d got de=%b d=%h", i, a_de, a_data); else pass_cnt++;
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int m = 1; m <= 21; m++) drive(m <= 18 ? tok[0] : 10'b0111111111, 1'b1);
    chk_cnt++; if ({a_locked, a_de, a_data} !== {2'b11, 8'h01}) $display("FAIL t6_pre got lk=%b de=%b d=%h want 1 1 01", a_locked, a_de, a_data); else pass_cnt++;
    #2 i_rst = 1'b1;
    #1;
    chk_cnt++; if ({a_valid, a_de, a_data, a_ctrl, a_token, a_locked, a_offset} !== 18'd0)
      $display("FAIL t6_async got %h want 0", {a_valid, a_de, a_data, a_ctrl, a_token, a_locked, a_offset}); else pass_cnt++;
    @(negedge clk);
    i_rst = 1'b0;
    for (int m = 1; m <= 18; m++) begin
      drive(tok[0], 1'b1);
      if (m == 17) begin
        chk_cnt++; if ({a_locked, a_offset} !== 5'd0) $display("FAIL t6_fresh_run got lk=%b off=%0d want 0 0", a_locked, a_offset); else pass_cnt++;
      end
    end
    chk_cnt++; if (a_locked !== 1'b1) $display("FAIL t6_relock got %b want 1", a_locked); else pass_cnt++;
  endtask

  initial begin
    prev_a = '0;
    test_reset();
    test_offset0();
    test_slip();
    test_loss();
    test_tokens();
    test_gaps();
    test_midreset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
